// File: rtl/pixel_stream_pkg.sv
// Shared definitions for the pixel stream demultiplexer.
//   DATA_W_DEFAULT : default pixel width (8-bit R,G,B packed)
//   state_t        : demux FSM states (SYNC waits for a frame start, RUN routes beats)
package pixel_stream_pkg;

   localparam int unsigned DATA_W_DEFAULT = 24;

   typedef enum logic {
      SYNC = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/pixel_out_reg.sv
// Single-entry output register for one demux destination.
// Ports:
//   Clock, Reset       : clock and synchronous active-high reset
//   load               : capture data/sof/eol this cycle (caller guarantees free_c)
//   data, sof, eol     : beat to capture
//   ready              : downstream accepts the held beat
//   m_data/m_valid/
//   m_sof/m_eol        : registered beat presented downstream
//   free_c             : combinational, entry can take a new beat this cycle
module pixel_out_reg
   import pixel_stream_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              load,
   input  logic [DATA_W-1:0] data,
   input  logic              sof,
   input  logic              eol,
   input  logic              ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   output logic              m_sof,
   output logic              m_eol,
   output logic              free_c
);

   // Empty, or the held beat leaves on this edge.
   assign free_c = !m_valid || ready;

   // Payload holds once drained; only valid drops.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         m_data  <= '0;
         m_valid <= 1'b0;
         m_sof   <= 1'b0;
         m_eol   <= 1'b0;
      end else if (load) begin
         m_data  <= data;
         m_valid <= 1'b1;
         m_sof   <= sof;
         m_eol   <= eol;
      end else if (m_valid && ready) begin
         m_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/pixel_stream_demux.sv
// Routes a pixel stream to one of two outputs, switching destination only at
// frame starts (SOF). After reset, beats are discarded until the first SOF.
// Optional feature macro: PIXEL_DEMUX_BROADCAST_EN adds input bcast; when the
// value latched at SOF is 1, every beat of that frame goes to both outputs.
// Ports:
//   Clock, Reset                  : clock, synchronous active-high reset
//   ctrl                          : requested destination, sampled on SOF
//   bcast (optional)              : broadcast request, sampled on SOF
//   s_data/s_valid/s_sof/s_eol    : input beat
//   s_ready                       : input beat accepted when s_valid && s_ready
//   m0_*/m1_*                     : registered destination streams
//   sel_o                         : currently latched destination
module pixel_stream_demux
   import pixel_stream_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              ctrl,
`ifdef PIXEL_DEMUX_BROADCAST_EN
   input  logic              bcast,
`endif
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_valid,
   input  logic              s_sof,
   input  logic              s_eol,
   output logic              s_ready,
   output logic [DATA_W-1:0] m0_data,
   output logic              m0_valid,
   output logic              m0_sof,
   output logic              m0_eol,
   input  logic              m0_ready,
   output logic [DATA_W-1:0] m1_data,
   output logic              m1_valid,
   output logic              m1_sof,
   output logic              m1_eol,
   input  logic              m1_ready,
   output logic              sel_o
);

   state_t state, state_next;
   logic   sel_next;
   logic   dest;
   logic   load0, load1;
   logic   free0, free1;
   logic   sof_accept;
   logic   bcast_now;

`ifdef PIXEL_DEMUX_BROADCAST_EN
   logic bcast_q;

   // Broadcast mode is latched alongside the destination on each accepted SOF.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         bcast_q <= 1'b0;
      end else if (sof_accept) begin
         bcast_q <= bcast;
      end
   end

   assign bcast_now = s_sof ? bcast : bcast_q;
`else
   assign bcast_now = 1'b0;
`endif

   // State and destination registers.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state <= SYNC;
         sel_o <= 1'b0;
      end else begin
         state <= state_next;
         sel_o <= sel_next;
      end
   end

   // Next state, routing and input handshake.
   always_comb begin
      state_next = state;
      sel_next   = sel_o;
      s_ready    = 1'b1;
      load0      = 1'b0;
      load1      = 1'b0;
      sof_accept = 1'b0;
      dest       = s_sof ? ctrl : sel_o;
      case (state)
         // Outputs are always empty here (only reset returns to SYNC),
         // so an SOF beat can be loaded unconditionally.
         SYNC: begin
            if (s_valid && s_sof) begin
               state_next = RUN;
               sel_next   = ctrl;
               sof_accept = 1'b1;
               load0      = bcast_now || !ctrl;
               load1      = bcast_now || ctrl;
            end
         end
         RUN: begin
            if (bcast_now) begin
               s_ready = free0 && free1;
            end else begin
               s_ready = dest ? free1 : free0;
            end
            if (s_valid && s_ready) begin
               load0 = bcast_now || !dest;
               load1 = bcast_now || dest;
               if (s_sof) begin
                  sel_next   = ctrl;
                  sof_accept = 1'b1;
               end
            end
         end
         default: begin
            state_next = SYNC;
         end
      endcase
   end

   pixel_out_reg #(.DATA_W(DATA_W)) u_out0 (
      .Clock   (Clock),
      .Reset   (Reset),
      .load    (load0),
      .data    (s_data),
      .sof     (s_sof),
      .eol     (s_eol),
      .ready   (m0_ready),
      .m_data  (m0_data),
      .m_valid (m0_valid),
      .m_sof   (m0_sof),
      .m_eol   (m0_eol),
      .free_c  (free0)
   );

   pixel_out_reg #(.DATA_W(DATA_W)) u_out1 (
      .Clock   (Clock),
      .Reset   (Reset),
      .load    (load1),
      .data    (s_data),
      .sof     (s_sof),
      .eol     (s_eol),
      .ready   (m1_ready),
      .m_data  (m1_data),
      .m_valid (m1_valid),
      .m_sof   (m1_sof),
      .m_eol   (m1_eol),
      .free_c  (free1)
   );

endmodule

// File: tb/tb_pixel_stream_demux.sv
// Directed bench for pixel_stream_demux: sync after reset, mid-frame ctrl
// changes, backpressure, reset mid-frame, full-rate line and (when
// PIXEL_DEMUX_BROADCAST_EN is defined) broadcast.
module tb_pixel_stream_demux;
   import pixel_stream_pkg::*;

   localparam int unsigned DW = 24;

   logic          Clock = 1'b0;
   logic          Reset;
   logic          ctrl;
`ifdef PIXEL_DEMUX_BROADCAST_EN
   logic          bcast;
`endif
   logic [DW-1:0] s_data;
   logic          s_valid, s_sof, s_eol, s_ready;
   logic [DW-1:0] m0_data, m1_data;
   logic          m0_valid, m0_sof, m0_eol, m0_ready;
   logic          m1_valid, m1_sof, m1_eol, m1_ready;
   logic          sel_o;

   int checks = 0;
   int errors = 0;
   int m0_cnt = 0;
   int m1_cnt = 0;

   always #5 Clock = ~Clock;

   pixel_stream_demux #(.DATA_W(DW)) dut (
      .Clock    (Clock),
      .Reset    (Reset),
      .ctrl     (ctrl),
`ifdef PIXEL_DEMUX_BROADCAST_EN
      .bcast    (bcast),
`endif
      .s_data   (s_data),
      .s_valid  (s_valid),
      .s_sof    (s_sof),
      .s_eol    (s_eol),
      .s_ready  (s_ready),
      .m0_data  (m0_data),
      .m0_valid (m0_valid),
      .m0_sof   (m0_sof),
      .m0_eol   (m0_eol),
      .m0_ready (m0_ready),
      .m1_data  (m1_data),
      .m1_valid (m1_valid),
      .m1_sof   (m1_sof),
      .m1_eol   (m1_eol),
      .m1_ready (m1_ready),
      .sel_o    (sel_o)
   );

   // Count completed downstream handshakes to detect lost/duplicated beats.
   always @(posedge Clock) begin
      if (m0_valid && m0_ready) m0_cnt++;
      if (m1_valid && m1_ready) m1_cnt++;
   end

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check_px(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Present one beat and advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic beat(input logic [DW-1:0] d, input logic sof, input logic eol, input logic c);
      s_valid = 1'b1;
      s_data  = d;
      s_sof   = sof;
      s_eol   = eol;
      ctrl    = c;
      @(posedge Clock);
      #1;
   endtask

   task automatic idle();
      s_valid = 1'b0;
      s_sof   = 1'b0;
      s_eol   = 1'b0;
      @(posedge Clock);
      #1;
   endtask

   initial begin
      int base0, base1, bad;
      logic [DW-1:0] px;

      Reset    = 1'b1;
      ctrl     = 1'b0;
`ifdef PIXEL_DEMUX_BROADCAST_EN
      bcast    = 1'b0;
`endif
      s_data   = '0;
      s_valid  = 1'b0;
      s_sof    = 1'b0;
      s_eol    = 1'b0;
      m0_ready = 1'b1;
      m1_ready = 1'b1;
      repeat (2) @(posedge Clock);
      #1;
      Reset = 1'b0;

      // Reset state
      check_bit("rst_m0_valid", m0_valid, 1'b0);
      check_bit("rst_m1_valid", m1_valid, 1'b0);
      check_bit("rst_sel", sel_o, 1'b0);
      check_px("rst_m0_data", m0_data, 24'h000000);
      check_px("rst_m1_data", m1_data, 24'h000000);
      check_bit("rst_state_sync", dut.state == SYNC, 1'b1);
      check_bit("rst_s_ready", s_ready, 1'b1);

      // Reset-then-sync: five non-SOF beats dropped, then SOF to m0
      for (int i = 1; i <= 5; i++) begin
         beat(DW'(i), 1'b0, 1'b0, 1'b0);
         check_bit("sync_drop_m0", m0_valid, 1'b0);
         check_bit("sync_drop_m1", m1_valid, 1'b0);
      end
      check_bit("sync_still_sync", dut.state == SYNC, 1'b1);
      beat(24'hFF0000, 1'b1, 1'b0, 1'b0);
      check_bit("sof_m0_valid", m0_valid, 1'b1);
      check_px("sof_m0_data", m0_data, 24'hFF0000);
      check_bit("sof_m0_sof", m0_sof, 1'b1);
      check_bit("sof_state_run", dut.state == RUN, 1'b1);
      idle();
      check_bit("sof_m0_drained", m0_valid, 1'b0);
      check_px("sof_m0_hold", m0_data, 24'hFF0000);

      // Mid-frame switch: 4x2 frame, ctrl goes high at pixel 3
      for (int i = 0; i < 8; i++) begin
         px = 24'h010100 + DW'(i);
         beat(px, i == 0, (i == 3) || (i == 7), i >= 3);
         check_bit("mid_m0_valid", m0_valid, 1'b1);
         check_px("mid_m0_data", m0_data, px);
         check_bit("mid_m1_valid", m1_valid, 1'b0);
      end
      check_bit("mid_m0_eol", m0_eol, 1'b1);
      check_bit("mid_sel_still0", sel_o, 1'b0);
      beat(24'hABCDEF, 1'b1, 1'b0, 1'b1);
      check_bit("next_m1_valid", m1_valid, 1'b1);
      check_px("next_m1_data", m1_data, 24'hABCDEF);
      check_bit("next_m1_sof", m1_sof, 1'b1);
      check_bit("next_sel", sel_o, 1'b1);
      check_bit("next_m0_idle", m0_valid, 1'b0);
      idle();

      // Backpressure on m0 for 4 cycles mid-line
      base0 = m0_cnt;
      beat(24'h000100, 1'b1, 1'b0, 1'b0);
      check_bit("bp_sel0", sel_o, 1'b0);
      m0_ready = 1'b0;
      s_valid  = 1'b1;
      s_data   = 24'h000101;
      s_sof    = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         check_bit("bp_s_ready_low", s_ready, 1'b0);
         @(posedge Clock);
         #1;
         check_px("bp_m0_stable", m0_data, 24'h000100);
         check_bit("bp_m0_valid", m0_valid, 1'b1);
      end
      m0_ready = 1'b1;
      #1;
      check_bit("bp_s_ready_high", s_ready, 1'b1);
      @(posedge Clock);
      #1;
      check_px("bp_next_beat", m0_data, 24'h000101);
      beat(24'h000102, 1'b0, 1'b1, 1'b0);
      check_px("bp_after", m0_data, 24'h000102);
      idle();
      check_int("bp_m0_count", m0_cnt - base0, 3);

      // Reset mid-frame while m1 holds a beat
      beat(24'h000200, 1'b1, 1'b0, 1'b1);
      beat(24'h000201, 1'b0, 1'b0, 1'b1);
      check_bit("rmid_m1_valid_pre", m1_valid, 1'b1);
      Reset = 1'b1;
      beat(24'h000202, 1'b0, 1'b0, 1'b1);
      Reset = 1'b0;
      check_bit("rmid_m1_valid", m1_valid, 1'b0);
      check_bit("rmid_state_sync", dut.state == SYNC, 1'b1);
      check_bit("rmid_sel", sel_o, 1'b0);
      check_px("rmid_m1_data", m1_data, 24'h000000);
      beat(24'h000203, 1'b0, 1'b0, 1'b1);
      beat(24'h000204, 1'b0, 1'b1, 1'b1);
      check_bit("rmid_drop_m1", m1_valid, 1'b0);
      check_bit("rmid_drop_m0", m0_valid, 1'b0);

      // Full rate: 640-pixel line to m1
      base1 = m1_cnt;
      bad   = 0;
      for (int i = 0; i < 640; i++) begin
         px       = 24'h300000 + DW'(i);
         s_valid  = 1'b1;
         s_data   = px;
         s_sof    = (i == 0);
         s_eol    = (i == 639);
         ctrl     = 1'b1;
         #1;
         if (s_ready !== 1'b1) bad++;
         @(posedge Clock);
         #1;
         if (m1_valid !== 1'b1 || m1_data !== px) bad++;
      end
      check_int("fr_stalls_or_bad", bad, 0);
      check_bit("fr_last_eol", m1_eol, 1'b1);
      check_bit("fr_last_sof", m1_sof, 1'b0);
      idle();
      check_int("fr_m1_count", m1_cnt - base1, 640);
      check_bit("fr_m1_drained", m1_valid, 1'b0);

`ifdef PIXEL_DEMUX_BROADCAST_EN
      // Broadcast frame: both outputs, m1 stall blocks input
      bcast = 1'b1;
      beat(24'h00FF00, 1'b1, 1'b0, 1'b0);
      bcast = 1'b0;
      check_bit("bc_m0_valid", m0_valid, 1'b1);
      check_bit("bc_m1_valid", m1_valid, 1'b1);
      check_px("bc_m0_data", m0_data, 24'h00FF00);
      check_px("bc_m1_data", m1_data, 24'h00FF00);
      m1_ready = 1'b0;
      s_valid  = 1'b1;
      s_data   = 24'h00FF01;
      s_sof    = 1'b0;
      #1;
      check_bit("bc_s_ready_low", s_ready, 1'b0);
      @(posedge Clock);
      #1;
      check_px("bc_m1_hold", m1_data, 24'h00FF00);
      m1_ready = 1'b1;
      #1;
      check_bit("bc_s_ready_high", s_ready, 1'b1);
      @(posedge Clock);
      #1;
      check_px("bc_m0_next", m0_data, 24'h00FF01);
      check_px("bc_m1_next", m1_data, 24'h00FF01);
      idle();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
